// File: rtl/cpu_mem_arbiter_if.sv
// Bundled CPU fetch, CPU load/store and shared-memory handshake signals for cpu_mem_arbiter.
// The master modport is the arbiter's view; slave is the surrounding CPU/memory side.
interface cpu_mem_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates CPU fetch and load/store requests onto one in-order memory port, routing responses via an ID queue.
// Define ARB_RR_EN for round-robin tie breaking; otherwise data requests have fixed priority.
module cpu_mem_arbiter #(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  cpu_mem_arbiter_if.master         bus,
  output logic                      arb_err
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_INST,
    GNT_DATA
  } gnt_t;

  gnt_t          gnt;
  gnt_t          gnt_next;
  logic [QDEPTH-1:0] id_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          err_q;
  logic          q_full;
  logic          q_empty;
  logic          granted;
  logic          sel_data;
  logic          push;
  logic          pop;
  logic          head_id;
  logic          pick_data;

  assign q_full   = (count == QFULL);
  assign q_empty  = (count == '0);
  assign granted  = (gnt != GNT_IDLE);
  assign sel_data = (gnt == GNT_DATA);
  assign push     = resetn & granted & bus.mem_addr_ok;
  assign pop      = resetn & bus.mem_data_ok & ~q_empty;
  assign head_id  = id_q[rd_ptr];

`ifdef ARB_RR_EN
  // Remembers who won the last accept so a tie goes to the other side.
  logic last_data;

  assign pick_data = bus.data_req & (~bus.inst_req | ~last_data);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_data <= 1'b0;
    end else if (push) begin
      last_data <= sel_data;
    end
  end
`else
  assign pick_data = bus.data_req;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      gnt <= GNT_IDLE;
    end else begin
      gnt <= gnt_next;
    end
  end

  always_comb begin
    gnt_next = gnt;
    case (gnt)
      GNT_IDLE: begin
        if (!q_full) begin
          if (pick_data) begin
            gnt_next = GNT_DATA;
          end else if (bus.inst_req) begin
            gnt_next = GNT_INST;
          end
        end
      end
      GNT_INST, GNT_DATA: begin
        if (bus.mem_addr_ok) begin
          gnt_next = GNT_IDLE;
        end
      end
      default: gnt_next = GNT_IDLE;
    endcase
  end

  // Requester-ID queue: 0 = fetch, 1 = load/store, drained in memory response order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        id_q[wr_ptr] <= sel_data;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.mem_data_ok && q_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.mem_req   = resetn & granted;
  assign bus.mem_wr    = sel_data & bus.data_wr;
  assign bus.mem_wstrb = sel_data ? bus.data_wstrb : 4'b0000;
  assign bus.mem_addr  = sel_data ? bus.data_addr  : bus.inst_addr;
  assign bus.mem_wdata = sel_data ? bus.data_wdata : 32'h0000_0000;

  assign bus.inst_addr_ok = resetn & bus.mem_addr_ok & (gnt == GNT_INST);
  assign bus.data_addr_ok = resetn & bus.mem_addr_ok & sel_data;

  assign bus.inst_data_ok = pop & ~head_id;
  assign bus.data_data_ok = pop & head_id;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  assign arb_err = resetn & err_q;

endmodule
